// File: rtl/riscv_base_mul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_base_mul_arbiter_pkg
// Description : Shared types and constants for the two-requester multiplier
//               arbiter: tag layout, id/rd widths, RV32M multiply encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_base_mul_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int ID_W = 1;
  localparam int RD_W = 5;

  // RV32M multiply encodings (opcode 0110011, funct7 0000001)
  localparam logic [31:0] INST_MUL_MASK    = 32'hFE00707F;
  localparam logic [31:0] INST_MUL         = 32'h02000033;
  localparam logic [31:0] INST_MULH        = 32'h02001033;
  localparam logic [31:0] INST_MULHSU      = 32'h02002033;
  localparam logic [31:0] INST_MULHU       = 32'h02003033;

  // One in-flight operation: owner id and destination register
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [RD_W-1:0] rd;
  } mul_tag_t;

  // True when the instruction word is one of the four multiply forms
  function automatic logic is_mul_op(input logic [31:0] op);
    logic [31:0] masked;
    masked = op & INST_MUL_MASK;
    return (masked == INST_MUL) || (masked == INST_MULH) ||
           (masked == INST_MULHSU) || (masked == INST_MULHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_base_mul_arbiter_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : riscv_base_mul_arbiter_tag_pipe
// Description : STAGES-deep shift register of {valid, id, rd} that travels in
//               lock-step with the multiplier pipeline; freezes on hold.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_base_mul_arbiter_tag_pipe
  import riscv_base_mul_arbiter_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     hold_i,
  input  mul_tag_t tag_in,
  output mul_tag_t tag_out,
  output logic     any_valid
);

  mul_tag_t stage_q [STAGES];

  // Shift the tags one stage per non-held cycle; reset drops everything in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else if (!hold_i) begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Any occupied stage means work is still in flight
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign tag_out = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/riscv_base_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_base_mul_arbiter
// Description : Round-robin arbiter sharing one pipelined multiplier between
//               two requesters; tags each issue and routes results back.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_base_mul_arbiter
  import riscv_base_mul_arbiter_pkg::*;
#(
  parameter int MULT_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [XLEN-1:0] req0_opcode_i,
  input  logic [XLEN-1:0] req0_ra_operand_i,
  input  logic [XLEN-1:0] req0_rb_operand_i,
  input  logic [RD_W-1:0] req0_rd_idx_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [XLEN-1:0] req1_opcode_i,
  input  logic [XLEN-1:0] req1_ra_operand_i,
  input  logic [XLEN-1:0] req1_rb_operand_i,
  input  logic [RD_W-1:0] req1_rd_idx_i,
  output logic            mul_valid_o,
  output logic [XLEN-1:0] mul_opcode_o,
  output logic [XLEN-1:0] mul_ra_operand_o,
  output logic [XLEN-1:0] mul_rb_operand_o,
  output logic [RD_W-1:0] mul_rd_idx_o,
  output logic            mul_hold_o,
  input  logic [XLEN-1:0] mul_result_i,
  output logic            resp0_valid_o,
  output logic [RD_W-1:0] resp0_rd_idx_o,
  output logic [XLEN-1:0] resp0_value_o,
  output logic            resp1_valid_o,
  output logic [RD_W-1:0] resp1_rd_idx_o,
  output logic [XLEN-1:0] resp1_value_o,
  output logic            busy_o
);

  logic     prio_q;
  logic     grant0;
  logic     grant1;
  mul_tag_t tag_in;
  mul_tag_t tag_last;
  logic     tags_busy;
  logic     resp_fire;

  // Grant a lone requester, or the one the pointer favours on a conflict
  always_comb begin
    grant0 = !hold_i && req0_valid_i && (!req1_valid_i || (prio_q == 1'b0));
    grant1 = !hold_i && req1_valid_i && (!req0_valid_i || (prio_q == 1'b1));
  end

  // Pointer moves to the loser after every grant so both sides alternate
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else if (grant0) begin
      prio_q <= 1'b1;
    end else if (grant1) begin
      prio_q <= 1'b0;
    end
  end

  // Steer the winner onto the multiplier port; zeros when nothing issues
  always_comb begin
    mul_valid_o      = grant0 | grant1;
    mul_opcode_o     = '0;
    mul_ra_operand_o = '0;
    mul_rb_operand_o = '0;
    mul_rd_idx_o     = '0;
    tag_in           = '0;
    if (grant0) begin
      mul_opcode_o     = req0_opcode_i;
      mul_ra_operand_o = req0_ra_operand_i;
      mul_rb_operand_o = req0_rb_operand_i;
      mul_rd_idx_o     = req0_rd_idx_i;
      tag_in           = '{valid: 1'b1, id: 1'b0, rd: req0_rd_idx_i};
    end else if (grant1) begin
      mul_opcode_o     = req1_opcode_i;
      mul_ra_operand_o = req1_ra_operand_i;
      mul_rb_operand_o = req1_rb_operand_i;
      mul_rd_idx_o     = req1_rd_idx_i;
      tag_in           = '{valid: 1'b1, id: 1'b1, rd: req1_rd_idx_i};
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign mul_hold_o   = hold_i;

  riscv_base_mul_arbiter_tag_pipe #(
    .STAGES (MULT_STAGES)
  ) u_tag_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .hold_i    (hold_i),
    .tag_in    (tag_in),
    .tag_out   (tag_last),
    .any_valid (tags_busy)
  );

  // Route the returning result to its owner; held cycles deliver nothing
  always_comb begin
    resp_fire      = tag_last.valid && !hold_i;
    resp0_valid_o  = resp_fire && (tag_last.id == 1'b0);
    resp1_valid_o  = resp_fire && (tag_last.id == 1'b1);
    resp0_rd_idx_o = resp0_valid_o ? tag_last.rd : '0;
    resp1_rd_idx_o = resp1_valid_o ? tag_last.rd : '0;
    resp0_value_o  = resp0_valid_o ? mul_result_i : '0;
    resp1_value_o  = resp1_valid_o ? mul_result_i : '0;
  end

  assign busy_o = tags_busy | req0_valid_i | req1_valid_i;

  // Non-M opcodes are legal here; they ride the pipe and return zero
  cover property (@(posedge clk_i) disable iff (rst_i)
                  mul_valid_o && !is_mul_op(mul_opcode_o));

endmodule
`default_nettype wire

// File: doc/riscv_base_mul_arbiter.md
# riscv_base_mul_arbiter

Round-robin arbiter and sequencer that shares one pipelined multiplier (MUL/MULH/MULHSU/MULHU, `MULT_STAGES`-deep) between two requesters, e.g. two issue slots or a core and a coprocessor port. It grants at most one request per cycle, drives the multiplier's opcode/operand inputs, and carries a tag (requester id, rd) alongside the multiplier pipeline. It routes each returning result to the owning requester's response port. It sits between the issue logic and the multiplier datapath and shares that datapath's `hold_i`.

## Interface
- `MULT_STAGES`, 2, multiplier latency in cycles from issue to valid result; tag pipeline depth

- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `hold_i`  in  1  pipeline stall; freezes arbiter, tags and multiplier
- `reqN_valid_i`  in  1  request from requester N (N = 0,1)
- `reqN_ready_o`  out  1  request N accepted this cycle
- `reqN_opcode_i`  in  32  instruction word
- `reqN_ra_operand_i`, `reqN_rb_operand_i`  in  32  source operands
- `reqN_rd_idx_i`  in  5  destination register
- `mul_valid_o`  out  1  issue strobe to multiplier
- `mul_opcode_o`  out  32  opcode to multiplier, 0 when idle
- `mul_ra_operand_o`, `mul_rb_operand_o`  out  32  operands, 0 when idle
- `mul_rd_idx_o`  out  5  rd to multiplier, 0 when idle
- `mul_hold_o`  out  1  equals `hold_i`
- `mul_result_i`  in  32  multiplier writeback value
- `respN_valid_o`  out  1  result for requester N valid this cycle
- `respN_rd_idx_o`  out  5  rd of returning op
- `respN_value_o`  out  32  result value, 0 when `respN_valid_o`=0
- `busy_o`  out  1  any tag in flight or any request pending

## Operation
- Priority pointer `prio_q` (1 bit). The pending requester equal to `prio_q` wins a conflict. Reset value 0.
- Grant rule (only when `hold_i`=0):
  - Only one requester valid: grant it.
  - Both valid: grant `prio_q`.
  - After any grant, `prio_q` <= the non-granted id.
  - No grant: `prio_q` unchanged.
- `reqN_ready_o` = grant to N. It is always 0 while `hold_i`=1. A request is consumed only when valid & ready.
- On grant, the granted request's fields are muxed onto `mul_*_o` and `mul_valid_o`=1. Otherwise all `mul_*_o` are 0.
- Every granted request enters the tag pipeline, including opcodes that are not M-mul. Those complete with value 0, matching the multiplier's clear-on-invalid behaviour, so requesters never deadlock.
- Tag pipeline: `MULT_STAGES` entries of {valid, id, rd}.
  - Shifts only when `hold_i`=0.
  - Entry 0 loads the grant (valid=0 if no grant).
- Response:
  - `respN_valid_o` = last tag valid & id==N & `hold_i`=0.
  - Value comes from `mul_result_i`; rd comes from the tag.
  - Responses are combinational from tag state. Held cycles give no response, so there are no duplicates.
- Reset mid-operation: all tags cleared, `prio_q`=0. No response in the cycle after reset, even for ops issued before it. The multiplier shares `rst_i`.

## Timing
- Reset values: all ready/valid outputs 0, `mul_*_o` 0, `resp*_value_o` 0, `busy_o` 0 (absent requests).
- Latency: a request accepted in cycle T responds in cycle T+`MULT_STAGES`, plus one cycle for each held cycle in between.
- Throughput: one issue per non-held cycle. With both requesters continuously valid, grants alternate 0,1,0,1.
- Simultaneous response and new grant in the same cycle are independent; both occur.
- `busy_o` is combinational: OR of tag valids and `reqN_valid_i`.

## Structure
- Shared package / `riscv_base_defines.v`:
  - `INST_MUL*` masks and matches, used only to flag non-M ops in assertions.
  - Requester-id width.
- Natural sub-module: `riscv_base_mul_tag_pipe`, a parameterised `MULT_STAGES` shift register of {valid, id, rd} with hold and sync clear.
- The top holds the arbiter, output muxing and response demux. Target size is about 150–250 lines.

## Test plan
- Single request: req0 MUL, ra=7, rb=6, rd=5 at cycle T → `resp0_valid_o`=1, rd=5, value=42 at T+2. `resp1_valid_o` stays 0.
- Conflict: both valid every cycle, req0 MULHU 0xFFFFFFFF×2, req1 MULH −1×−1 → grants alternate 0,1,0 from reset. Responses 0x00000001 on resp0 and 0x00000000 on resp1, each 2 cycles after its grant.
- Hold: `hold_i`=1 for 3 cycles right after a grant at T → no ready, no response while held. The response arrives at T+5 exactly once.
- Non-M opcode (ADD) on req1 → accepted, `resp1_valid_o`=1 with value 0 at T+2.
- Reset mid-flight: grant at T, `rst_i`=1 at T+1 → no response at T+2, `prio_q`=0, `busy_o`=0 with idle requesters.
